// File: rtl/id_stage_pipelined.sv
// ARMv8 (LEGv8 subset) decode stage: decoder, register file, load-use detection, ID/EX register.
// Define ID_BYPASS_EN to make a same-cycle writeback visible to the register-file read ports.
module id_stage_pipelined #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              flush,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rd,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic              wb_link,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc_link,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [4:0]        rn_out,
    output logic [4:0]        rm_out,
    output logic [4:0]        rd_out,
    output logic [9:0]        ctrl_out,
    output logic [1:0]        aluop_out
);

    localparam logic [4:0] XZR = 5'(NREG - 1);

    // ctrl bit order: memread, memtoreg, memwrite, alusrc, regwrite,
    //                 branch, uncondbranch, branchlink, branchreg, not_zero
    localparam logic [9:0] CtrlLdur = 10'b11_0110_0000;
    localparam logic [9:0] CtrlStur = 10'b00_1100_0000;
    localparam logic [9:0] CtrlRtyp = 10'b00_0010_0000;
    localparam logic [9:0] CtrlBr   = 10'b00_0000_1010;
    localparam logic [9:0] CtrlCbz  = 10'b00_0001_0000;
    localparam logic [9:0] CtrlCbnz = 10'b00_0001_0001;
    localparam logic [9:0] CtrlB    = 10'b00_0000_1000;
    localparam logic [9:0] CtrlBl   = 10'b00_0010_1100;

    logic [DATA_W-1:0] rf [NREG];

    logic [9:0]        ctrl_d;
    logic [1:0]        aluop_d;
    logic              reg2loc;
    logic              is_bl;
    logic [DATA_W-1:0] imm_d;
    logic [4:0]        rn_idx;
    logic [4:0]        rm_idx;
    logic [4:0]        rd_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              bubble;

    always_comb begin
        ctrl_d  = '0;
        aluop_d = 2'b00;
        reg2loc = 1'b0;
        is_bl   = 1'b0;
        imm_d   = '0;
        casez (instruction[31:21])
            11'h7C2: begin
                ctrl_d = CtrlLdur;
                imm_d  = DATA_W'($signed(instruction[20:12]));
            end
            11'h7C0: begin
                ctrl_d  = CtrlStur;
                reg2loc = 1'b1;
                imm_d   = DATA_W'($signed(instruction[20:12]));
            end
            11'h458, 11'h658, 11'h450, 11'h550: begin
                ctrl_d  = CtrlRtyp;
                aluop_d = 2'b10;
            end
            11'h6B0: ctrl_d = CtrlBr;
            11'b1011_0100_???, 11'b1011_0101_???: begin
                ctrl_d  = instruction[24] ? CtrlCbnz : CtrlCbz;
                aluop_d = 2'b01;
                reg2loc = 1'b1;
                imm_d   = DATA_W'($signed(instruction[23:5]));
            end
            11'b0001_01??_???, 11'b1001_01??_???: begin
                is_bl  = instruction[31];
                ctrl_d = instruction[31] ? CtrlBl : CtrlB;
                imm_d  = DATA_W'($signed(instruction[25:0]));
            end
            default: ;
        endcase
    end

    assign rn_idx  = instruction[9:5];
    assign rm_idx  = reg2loc ? instruction[4:0] : instruction[20:16];
    // BL has no Rd field; its link target is fixed at X30
    assign rd_idx  = is_bl ? 5'd30 : instruction[4:0];
    assign wr_data = wb_link ? wb_pc_link : wb_data;

    always_comb begin
        rd1 = (rn_idx == XZR) ? '0 : rf[rn_idx];
        rd2 = (rm_idx == XZR) ? '0 : rf[rm_idx];
`ifdef ID_BYPASS_EN
        if (wb_we && wb_addr != XZR && wb_addr == rn_idx) rd1 = wr_data;
        if (wb_we && wb_addr != XZR && wb_addr == rm_idx) rd2 = wr_data;
`endif
    end

    assign stall = !reset && !flush && in_valid && ex_memread && ex_rd != 5'd31 &&
                   (ex_rd == rn_idx || ex_rd == rm_idx);

    assign bubble = flush || stall || !in_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (wb_we && wb_addr != XZR) begin
            rf[wb_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            rd_data1  <= '0;
            rd_data2  <= '0;
            imm_out   <= '0;
            pc_out    <= '0;
            rn_out    <= '0;
            rm_out    <= '0;
            rd_out    <= '0;
            ctrl_out  <= '0;
            aluop_out <= '0;
        end else begin
            // Datapath fields load unconditionally; a bubble is marked by valid/ctrl only
            rd_data1 <= rd1;
            rd_data2 <= rd2;
            imm_out  <= imm_d;
            pc_out   <= pc_in;
            rn_out   <= rn_idx;
            rm_out   <= rm_idx;
            rd_out   <= rd_idx;
            if (bubble) begin
                out_valid <= 1'b0;
                ctrl_out  <= '0;
                aluop_out <= '0;
            end else begin
                out_valid <= 1'b1;
                ctrl_out  <= ctrl_d;
                aluop_out <= aluop_d;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed self-checking bench for id_stage_pipelined; expectations follow ID_BYPASS_EN.
module tb_id_stage_pipelined;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [63:0] pc_in;
    logic        flush;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic        wb_link;
    logic [63:0] wb_data;
    logic [63:0] wb_pc_link;
    logic        stall;
    logic        out_valid;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;
    logic [63:0] imm_out;
    logic [63:0] pc_out;
    logic [4:0]  rn_out;
    logic [4:0]  rm_out;
    logic [4:0]  rd_out;
    logic [9:0]  ctrl_out;
    logic [1:0]  aluop_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    id_stage_pipelined #(.DATA_W(64), .NREG(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .pc_in(pc_in), .flush(flush), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_link(wb_link), .wb_data(wb_data),
        .wb_pc_link(wb_pc_link), .stall(stall), .out_valid(out_valid),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .imm_out(imm_out), .pc_out(pc_out),
        .rn_out(rn_out), .rm_out(rm_out), .rd_out(rd_out), .ctrl_out(ctrl_out),
        .aluop_out(aluop_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    localparam logic [10:0] OpAdd = 11'h458;
    localparam logic [10:0] OpSub = 11'h658;
    localparam logic [63:0] Ones  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [63:0] exp_bypass;

    initial begin
        reset = 1'b1; in_valid = 1'b1; pc_in = 64'h100; flush = 1'b0;
        ex_memread = 1'b1; ex_rd = 5'd3; wb_we = 1'b1; wb_addr = 5'd3; wb_link = 1'b0;
        wb_data = 64'hAAAA; wb_pc_link = 64'h0;
        instruction = rtype(OpAdd, 5'd3, 5'd3, 5'd1);
        #1;
        check("stall_in_reset", {63'd0, stall}, 64'd0);
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ctrl", {54'd0, ctrl_out}, 64'd0);
        check("rst_rd1", rd_data1, 64'd0);
        check("rst_pc", pc_out, 64'd0);

        // Register file cleared by reset (writeback was asserted alongside it)
        reset = 1'b0; ex_memread = 1'b0; wb_we = 1'b0;
        for (int i = 0; i < 31; i++) begin
            instruction = rtype(OpAdd, 5'(30 - i), 5'(i), 5'd0);
            tick();
            check($sformatf("zero_rd1_x%0d", i), rd_data1, 64'd0);
            check($sformatf("zero_rd2_x%0d", 30 - i), rd_data2, 64'd0);
        end
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_ctrl", {54'd0, ctrl_out}, 64'h020);
        check("add_aluop", {62'd0, aluop_out}, 64'd2);

        // Same-cycle write and read of X3
`ifdef ID_BYPASS_EN
        exp_bypass = 64'h1234;
`else
        exp_bypass = 64'h0;
`endif
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234; pc_in = 64'h200;
        instruction = rtype(OpAdd, 5'd3, 5'd3, 5'd1);
        tick();
        check("same_cycle_rd1", rd_data1, exp_bypass);
        check("same_cycle_rd2", rd_data2, exp_bypass);
        check("pc_out", pc_out, 64'h200);
        wb_we = 1'b0;
        tick();
        check("next_cycle_rd1", rd_data1, 64'h1234);
        check("add_rn", {59'd0, rn_out}, 64'd3);
        check("add_rd", {59'd0, rd_out}, 64'd1);

        // Load-use hazard against SUB X4,X2,X5
        instruction = rtype(OpSub, 5'd5, 5'd2, 5'd4);
        ex_memread = 1'b1; ex_rd = 5'd2;
        #1;
        check("stall_rn", {63'd0, stall}, 64'd1);
        tick();
        check("stall_bubble_valid", {63'd0, out_valid}, 64'd0);
        check("stall_bubble_ctrl", {54'd0, ctrl_out}, 64'd0);
        check("stall_bubble_aluop", {62'd0, aluop_out}, 64'd0);
        ex_rd = 5'd5; #1;
        check("stall_rm", {63'd0, stall}, 64'd1);
        ex_rd = 5'd6; #1;
        check("no_stall_other", {63'd0, stall}, 64'd0);
        ex_memread = 1'b0; ex_rd = 5'd2; #1;
        check("no_stall_not_load", {63'd0, stall}, 64'd0);
        instruction = rtype(OpSub, 5'd5, 5'd31, 5'd4); ex_memread = 1'b1; ex_rd = 5'd31; #1;
        check("no_stall_xzr", {63'd0, stall}, 64'd0);
        ex_memread = 1'b0;
        tick();
        check("sub_valid", {63'd0, out_valid}, 64'd1);
        check("sub_ctrl", {54'd0, ctrl_out}, 64'h020);

        // LDUR X1,[X2,#-8]
        instruction = {11'h7C2, 9'h1F8, 2'b00, 5'd2, 5'd1};
        tick();
        check("ldur_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_ctrl", {54'd0, ctrl_out}, 64'h360);
        check("ldur_aluop", {62'd0, aluop_out}, 64'd0);
        check("ldur_rn", {59'd0, rn_out}, 64'd2);

        // STUR X3,[X2,#16]: Reg2Loc selects Rt on port 2
        instruction = {11'h7C0, 9'd16, 2'b00, 5'd2, 5'd3};
        tick();
        check("stur_rm", {59'd0, rm_out}, 64'd3);
        check("stur_rd2", rd_data2, 64'h1234);
        check("stur_imm", imm_out, 64'd16);
        check("stur_ctrl", {54'd0, ctrl_out}, 64'h0C0);

        // BL with link writeback into X30, then an ignored write to X31
        instruction = {6'h25, 26'h3FF_FFFF};
        wb_we = 1'b1; wb_link = 1'b1; wb_addr = 5'd30; wb_pc_link = 64'h400;
        wb_data = 64'hDEAD;
        tick();
        check("bl_ctrl", {54'd0, ctrl_out}, 64'h02C);
        check("bl_imm", imm_out, Ones);
        check("bl_rd", {59'd0, rd_out}, 64'd30);
        wb_link = 1'b0; wb_addr = 5'd31; wb_data = 64'h5555;
        instruction = rtype(OpAdd, 5'd31, 5'd30, 5'd0);
        tick();
        check("x30_link", rd_data1, 64'h400);
        check("x31_same", rd_data2, 64'd0);
        wb_we = 1'b0;
        instruction = rtype(OpAdd, 5'd30, 5'd31, 5'd0);
        tick();
        check("x31_after", rd_data1, 64'd0);
        check("x30_port2", rd_data2, 64'h400);

        // CBNZ X7 with load-use, then flush
        instruction = {8'hB5, 19'd4, 5'd7};
        ex_memread = 1'b1; ex_rd = 5'd7; #1;
        check("cbnz_stall", {63'd0, stall}, 64'd1);
        flush = 1'b1; #1;
        check("flush_kills_stall", {63'd0, stall}, 64'd0);
        tick();
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ctrl", {54'd0, ctrl_out}, 64'd0);
        flush = 1'b0; ex_memread = 1'b0;
        tick();
        check("cbnz_ctrl", {54'd0, ctrl_out}, 64'h011);
        check("cbnz_aluop", {62'd0, aluop_out}, 64'd1);
        check("cbnz_imm", imm_out, 64'd4);
        check("cbnz_rm", {59'd0, rm_out}, 64'd7);

        // CBZ with negative offset, B, BR
        instruction = {8'hB4, 19'h7FFFE, 5'd0};
        tick();
        check("cbz_ctrl", {54'd0, ctrl_out}, 64'h010);
        check("cbz_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFE);
        instruction = {6'h05, 26'd12};
        tick();
        check("b_ctrl", {54'd0, ctrl_out}, 64'h008);
        check("b_imm", imm_out, 64'd12);
        instruction = {11'h6B0, 5'd31, 6'd0, 5'd30, 5'd0};
        tick();
        check("br_ctrl", {54'd0, ctrl_out}, 64'h00A);

        // in_valid low, and an unknown opcode
        in_valid = 1'b0; instruction = rtype(OpAdd, 5'd1, 5'd1, 5'd1);
        tick();
        check("invalid_valid", {63'd0, out_valid}, 64'd0);
        check("invalid_ctrl", {54'd0, ctrl_out}, 64'd0);
        in_valid = 1'b1; instruction = 32'h0000_0000;
        tick();
        check("nop_ctrl", {54'd0, ctrl_out}, 64'd0);
        check("nop_imm", imm_out, 64'd0);

        // Reset wins over writeback and flush
        reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h77; flush = 1'b1;
        instruction = rtype(OpAdd, 5'd3, 5'd5, 5'd0);
        tick();
        check("rst2_valid", {63'd0, out_valid}, 64'd0);
        reset = 1'b0; wb_we = 1'b0; flush = 1'b0;
        tick();
        check("rst2_x5", rd_data1, 64'd0);
        check("rst2_x3", rd_data2, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
